// File: rtl/freq_counter_pkg.sv
// Shared encodings for the multi-channel gated edge counter.
package freq_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

endpackage

// File: rtl/freq_counter_chan.sv
// One measurement channel: synchroniser, edge qualifier, saturating counter and
// the result register that holds the last completed window.
module freq_counter_chan
  import freq_counter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SAT_MAX     = 250,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             sig_in,
  input  logic             clear_in,
  input  logic             latch_in,
  input  logic [1:0]       edge_mode_in,
  output logic [CNT_W-1:0] cnt_lat_out,
  output logic             sat_out
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT_MAX);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       lat_q, lat_d;
  logic                   sat_q, sat_d;
  logic                   rise, fall, edge_hit;
  logic [CNT_W-1:0]       cnt_inc;

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

  always_comb begin
    edge_hit = rise;
    case (edge_mode_in)
      EDGE_FALL: edge_hit = fall;
      EDGE_BOTH: edge_hit = rise | fall;
      default:   edge_hit = rise;
    endcase
  end

  // SAT_MAX fits in CNT_W, so the increment below the ceiling cannot overflow.
  assign cnt_inc = (cnt_q == SAT_V) ? cnt_q : cnt_q + CNT_W'(edge_hit);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = sync_q[SYNC_STAGES-1];
    cnt_d  = cnt_inc;
    lat_d  = lat_q;
    sat_d  = sat_q;
    if (clear_in) begin
      cnt_d = '0;
    end else if (latch_in) begin
      lat_d = cnt_inc;
      sat_d = (cnt_inc == SAT_V);
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
      lat_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      lat_q  <= lat_d;
      sat_q  <= sat_d;
    end
  end

  assign cnt_lat_out = lat_q;
  assign sat_out     = sat_q;

endmodule

// File: rtl/freq_counter_multi.sv
// Multi-channel gated edge counter: window FSM, valid strobe and output packing.
// Results change only on a gate seen in COUNT with enable high.
module freq_counter_multi
  import freq_counter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int SAT_MAX     = 250,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    enable_in,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic                    gate_in,
  input  logic [1:0]              edge_mode_in,
  output logic [NUM_CH*CNT_W-1:0] data_out,
  output logic [NUM_CH-1:0]       sat_out,
  output logic                    valid_out,
  output logic [1:0]              state_out
);

  state_e state_q, state_d;
  logic   valid_q, valid_d;
  logic   clear_w, latch_w;

  // Dropping enable wins over a coincident gate: no latch on the way out.
  assign latch_w = (state_q == ST_COUNT) && enable_in && gate_in;
  assign clear_w = !((state_q == ST_COUNT) && enable_in);

  always_comb begin
    state_d = state_q;
    valid_d = latch_w;
    case (state_q)
      ST_IDLE:  if (enable_in) state_d = ST_ARM;
      ST_ARM: begin
        if (!enable_in)   state_d = ST_IDLE;
        else if (gate_in) state_d = ST_COUNT;
      end
      ST_COUNT: if (!enable_in) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    freq_counter_chan #(
      .CNT_W      (CNT_W),
      .SAT_MAX    (SAT_MAX),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .sig_in      (sig_in[k]),
      .clear_in    (clear_w),
      .latch_in    (latch_w),
      .edge_mode_in(edge_mode_in),
      .cnt_lat_out (data_out[k*CNT_W +: CNT_W]),
      .sat_out     (sat_out[k])
    );
  end

  assign valid_out = valid_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_freq_counter_multi.sv
// Directed bench for freq_counter_multi (4 channels, 8-bit counts, ceiling 250).
module tb_freq_counter_multi;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        enable_in;
  logic [3:0]  sig_in;
  logic        gate_in;
  logic [1:0]  edge_mode_in;
  logic [31:0] data_out;
  logic [3:0]  sat_out;
  logic        valid_out;
  logic [1:0]  state_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  freq_counter_multi dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .enable_in   (enable_in),
    .sig_in      (sig_in),
    .gate_in     (gate_in),
    .edge_mode_in(edge_mode_in),
    .data_out    (data_out),
    .sat_out     (sat_out),
    .valid_out   (valid_out),
    .state_out   (state_out)
  );

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Each pulse is 2 cycles high, 2 low; then let the pipeline drain.
  task automatic drive_pulses(input int c0, input int c1, input int c2, input int c3);
    int mx;
    mx = c0;
    if (c1 > mx) mx = c1;
    if (c2 > mx) mx = c2;
    if (c3 > mx) mx = c3;
    for (int i = 0; i < mx; i++) begin
      sig_in = {(i < c3), (i < c2), (i < c1), (i < c0)};
      tick(2);
      sig_in = 4'h0;
      tick(2);
    end
    tick(4);
  endtask

  task automatic arm_window();
    enable_in = 1'b1;
    tick(1);
    gate_in = 1'b1;
    tick(1);
    gate_in = 1'b0;
    tests_run++;
    if (valid_out !== 1'b0) begin
      $display("FAIL arm_no_valid: valid_out=%b required 0", valid_out);
      tests_failed++;
    end
    tests_run++;
    if (state_out !== 2'd2) begin
      $display("FAIL arm_to_count: state_out=%0d required 2", state_out);
      tests_failed++;
    end
  endtask

  task automatic close_window(input string name, input logic [31:0] exp_d, input logic [3:0] exp_s);
    gate_in = 1'b1;
    tick(1);
    gate_in = 1'b0;
    tests_run++;
    if (valid_out !== 1'b1) begin
      $display("FAIL %s valid_pulse: valid_out=%b required 1", name, valid_out);
      tests_failed++;
    end
    tests_run++;
    if (data_out !== exp_d || sat_out !== exp_s) begin
      $display("FAIL %s data: data_out=%h sat_out=%b required %h %b", name, data_out, sat_out, exp_d, exp_s);
      tests_failed++;
    end
    tick(1);
    tests_run++;
    if (valid_out !== 1'b0 || data_out !== exp_d) begin
      $display("FAIL %s hold: valid_out=%b data_out=%h required 0 %h", name, valid_out, data_out, exp_d);
      tests_failed++;
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    enable_in = 1'b1;
    gate_in = 1'b1;
    sig_in = 4'hF;
    edge_mode_in = 2'b00;
    tick(3);
    tests_run++;
    if (state_out !== 2'd0 || data_out !== 32'h0 || sat_out !== 4'h0 || valid_out !== 1'b0) begin
      $display("FAIL reset_state: state=%0d data=%h sat=%b valid=%b required 0 0 0 0",
               state_out, data_out, sat_out, valid_out);
      tests_failed++;
    end
    rst_n_in = 1'b1;
    enable_in = 1'b0;
    gate_in = 1'b0;
    sig_in = 4'h0;
    tick(4);
  endtask

  task automatic test_multi_channel();
    arm_window();
    drive_pulses(10, 3, 0, 250);
    close_window("multi_ch", 32'hFA00_030A, 4'b1000);
    tick(5);
    tests_run++;
    if (data_out !== 32'hFA00_030A || sat_out !== 4'b1000) begin
      $display("FAIL multi_ch_stable: data_out=%h sat_out=%b required fa00030a 1000", data_out, sat_out);
      tests_failed++;
    end
  endtask

  task automatic test_saturation();
    drive_pulses(0, 0, 0, 0);
    close_window("flush", 32'h0, 4'h0);
    drive_pulses(300, 0, 0, 0);
    close_window("sat_300", 32'h0000_00FA, 4'b0001);
    drive_pulses(5, 0, 0, 0);
    close_window("sat_after", 32'h0000_0005, 4'b0000);
  endtask

  task automatic test_edge_modes();
    logic [1:0] modes [4];
    logic [7:0] exps [4];
    modes = '{2'b00, 2'b01, 2'b10, 2'b11};
    exps  = '{8'd6, 8'd6, 8'd12, 8'd6};
    for (int m = 0; m < 4; m++) begin
      enable_in = 1'b0;
      tick(2);
      edge_mode_in = modes[m];
      arm_window();
      drive_pulses(6, 0, 0, 0);
      close_window($sformatf("mode_%0d", m), {24'h0, exps[m]}, 4'h0);
    end
    enable_in = 1'b0;
    tick(2);
    edge_mode_in = 2'b00;
  endtask

  task automatic test_gate_cycle_edge();
    arm_window();
    drive_pulses(4, 0, 0, 0);
    sig_in = 4'h1;
    tick(2);
    close_window("gate_edge", 32'h0000_0005, 4'h0);
    tick(3);
    sig_in = 4'h0;
    tick(5);
    close_window("after_gate_edge", 32'h0, 4'h0);
  endtask

  task automatic test_partial_window();
    enable_in = 1'b0;
    tick(2);
    enable_in = 1'b1;
    tick(1);
    tests_run++;
    if (state_out !== 2'd1) begin
      $display("FAIL partial_arm: state_out=%0d required 1", state_out);
      tests_failed++;
    end
    drive_pulses(7, 0, 0, 0);
    gate_in = 1'b1;
    tick(1);
    gate_in = 1'b0;
    tests_run++;
    if (valid_out !== 1'b0 || state_out !== 2'd2) begin
      $display("FAIL partial_first_gate: valid=%b state=%0d required 0 2", valid_out, state_out);
      tests_failed++;
    end
    drive_pulses(4, 0, 0, 0);
    close_window("partial_second", 32'h0000_0004, 4'h0);
  endtask

  task automatic test_disable_with_gate();
    drive_pulses(3, 2, 0, 0);
    enable_in = 1'b0;
    gate_in = 1'b1;
    tick(1);
    gate_in = 1'b0;
    tests_run++;
    if (valid_out !== 1'b0 || state_out !== 2'd0 || data_out !== 32'h0000_0004) begin
      $display("FAIL disable_gate: valid=%b state=%0d data=%h required 0 0 00000004",
               valid_out, state_out, data_out);
      tests_failed++;
    end
    tick(1);
    tests_run++;
    if (valid_out !== 1'b0) begin
      $display("FAIL disable_gate_late: valid_out=%b required 0", valid_out);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_count();
    arm_window();
    drive_pulses(6, 0, 0, 0);
    close_window("pre_reset", 32'h0000_0006, 4'h0);
    drive_pulses(37, 0, 0, 0);
    rst_n_in = 1'b0;
    gate_in = 1'b1;
    tick(1);
    rst_n_in = 1'b1;
    gate_in = 1'b0;
    tests_run++;
    if (state_out !== 2'd0 || data_out !== 32'h0 || sat_out !== 4'h0 || valid_out !== 1'b0) begin
      $display("FAIL reset_mid_count: state=%0d data=%h sat=%b valid=%b required 0 0 0 0",
               state_out, data_out, sat_out, valid_out);
      tests_failed++;
    end
    arm_window();
    close_window("post_reset_empty", 32'h0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_multi_channel();
    test_saturation();
    test_edge_modes();
    test_gate_cycle_edge();
    test_partial_window();
    test_disable_with_gate();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/freq_counter_multi.md
Name: freq_counter_multi

Overview:
Parametrised, multi-channel successor to the single-channel positive-edge counter. It counts qualified edges on N asynchronous input signals over a window bounded by periodic gate pulses, such as the 0.25 s timebase. Per-channel counts and saturation flags are latched at each gate, with a one-cycle valid strobe, for the UART transmit path.
Improvements over the previous block:
- edge detection every clock, not every third;
- input synchronisation;
- selectable edge mode;
- true reset;
- results held stable between gates.

Parameters:
NUM_CH, 4, number of input channels (1..16)
CNT_W, 8, per-channel count width
SAT_MAX, 250, saturation ceiling; must be <= 2^CNT_W-1
SYNC_STAGES, 2, synchroniser depth on each sig_in bit (>=2)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  synchronous, active-low reset
enable_in  input  1  1 = run; 0 = idle, counters cleared
sig_in  input  NUM_CH  asynchronous signals to measure
gate_in  input  1  one-cycle window-boundary pulse
edge_mode_in  input  2  00 rising, 01 falling, 10 both, 11 reserved (treated as rising)
data_out  output  NUM_CH*CNT_W  latched counts; channel k at bits [k*CNT_W +: CNT_W]
sat_out  output  NUM_CH  per-channel flag: the latched count hit SAT_MAX
valid_out  output  1  one-cycle pulse when data_out/sat_out update
state_out  output  2  FSM state, for debug

Behaviour:
- Reset: rst_n_in=0 sampled at a clk_in edge forces the following; reset overrides all other inputs.
  - state IDLE;
  - all synchroniser and history flops to 0;
  - counters to 0;
  - data_out, sat_out, valid_out to 0.
- Input path, per channel: SYNC_STAGES flops, then one history flop.
  - Edge detect compares the last synchroniser stage with the history flop every cycle.
  - Rising = 0->1; falling = 1->0; both = either.
  - Latency from sig_in transition to the counter increment: SYNC_STAGES+1 clk_in edges.
- Counter: cnt <= min(cnt + edge, SAT_MAX). A counter never wraps; once at SAT_MAX it holds.
- FSM states are IDLE, ARM, COUNT.
  - IDLE: counters held at 0; data_out retained. If enable_in=1 -> ARM.
  - ARM: discards the partial first window. Counters held at 0. On gate_in=1 -> COUNT with counters 0; no valid_out. If enable_in=0 -> IDLE.
  - COUNT: counters accumulate. On gate_in=1, in the same clock edge:
    - data_out[k] <= min(cnt[k] + edge[k], SAT_MAX); an edge in the gate cycle belongs to the closing window;
    - sat_out[k] <= (that value == SAT_MAX);
    - cnt[k] <= 0;
    - valid_out <= 1 on the next cycle only;
    - state stays COUNT.
  - COUNT, enable_in=0: -> IDLE; counters cleared; no latch, even if gate_in=1 in the same cycle; data_out and sat_out keep the last window.
- gate_in held high for several cycles: every high cycle in COUNT is a window boundary. The windows after the first are 1 cycle long. Upstream guarantees single-cycle pulses.
- edge_mode_in is sampled every cycle; a change takes effect immediately. It should only be changed in IDLE, and results of a window spanning a change are undefined-but-bounded (<= SAT_MAX).
- The synchroniser runs in every state, so there is no edge burst on leaving IDLE. The history flop keeps tracking, so no false edge appears on entering ARM.
- Maximum countable rate: one edge every 2 clk_in cycles per channel (one every cycle in both-edge mode on alternating input).

Decomposition:
- Package freq_counter_pkg:
  - state encodings ST_IDLE=2'd0, ST_ARM=2'd1, ST_COUNT=2'd2;
  - edge-mode constants EDGE_RISE, EDGE_FALL, EDGE_BOTH.
- Sub-module freq_counter_chan, one per channel via generate:
  - synchroniser, history flop, edge qualifier, saturating counter, latch register;
  - inputs: clear, latch, edge_mode.
- The top level holds the FSM, valid_out generation and output packing.

Test Plan:
- Reset mid-COUNT with cnt[0]=37 -> next cycle: state IDLE, data_out=0, sat_out=0, valid_out=0; the reset also overrides gate_in=1 in the same cycle.
- NUM_CH=4, rising mode: ch0 gets 10 pulses, ch1 3, ch2 0, ch3 250. Sequence: enable, gate (ARM->COUNT), pulses, gate.
  - Required: valid_out high exactly 1 cycle later.
  - data_out = {250,0,3,10}, sat_out=4'b1000.
- Saturation: 300 rising edges on ch0 in one window -> data_out[0]=250, sat_out[0]=1. Next window with 5 edges -> 5, sat_out[0]=0 (no wrap, no carry-over).
- Edge modes on 6 full input periods: rising -> 6, falling -> 6, both -> 12. Edge landing exactly in the gate cycle -> counted in the closing window; the next window starts at 0.
- Partial first window: 7 edges between enable and first gate -> no valid_out, and the second gate reports only edges after the first gate.
- enable_in dropped in COUNT with gate_in=1 in the same cycle -> no valid_out; data_out keeps the prior value; state IDLE.
